// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder with valid/ready handshakes. It produces one sum bit per clock, LSB first.
// Define SERIAL_ADDER_SUB_EN to add a 'sub' port that computes a - b instead of a + b + cin.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADD,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic             r_carry;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;

    // Full-adder slice built from two half-adders and an OR.
    logic w_ha1_s, w_ha1_c, w_ha2_s, w_ha2_c, w_c_next;
    assign w_ha1_s  = r_a_sh[0] ^ r_b_sh[0];
    assign w_ha1_c  = r_a_sh[0] & r_b_sh[0];
    assign w_ha2_s  = w_ha1_s ^ r_carry;
    assign w_ha2_c  = w_ha1_s & r_carry;
    assign w_c_next = w_ha1_c | w_ha2_c;

    logic [WIDTH-1:0] w_sum_next;
    generate
        if (WIDTH == 1) begin : g_w1
            assign w_sum_next = w_ha2_s;
        end else begin : g_wn
            assign w_sum_next = {w_ha2_s, r_sum[WIDTH-1:1]};
        end
    endgenerate

    logic [WIDTH-1:0] w_b_load;
    logic             w_c_load;
`ifdef SERIAL_ADDER_SUB_EN
    // Two's-complement subtract: invert b and force the carry-in to 1.
    assign w_b_load = sub ? ~b : b;
    assign w_c_load = sub ? 1'b1 : cin;
`else
    assign w_b_load = b;
    assign w_c_load = cin;
`endif

    // NOTE: every state register here is an ordinary flop, so each one resets and updates with <= only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_a_sh  <= '0;
            r_b_sh  <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a_sh  <= a;
                        r_b_sh  <= w_b_load;
                        r_carry <= w_c_load;
                        r_cnt   <= '0;
                        r_state <= S_ADD;
                    end
                end
                S_ADD: begin
                    r_sum   <= w_sum_next;
                    r_a_sh  <= r_a_sh >> 1;
                    r_b_sh  <= r_b_sh >> 1;
                    r_carry <= w_c_next;
                    r_cnt   <= r_cnt + CW'(1);
                    if (r_cnt == CW'(WIDTH - 1)) begin
                        r_cout  <= w_c_next;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // The handshake flags depend only on the registered state.
    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign busy      = (r_state != S_IDLE);
    assign sum       = r_sum;
    assign cout      = r_cout;

endmodule

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder (WIDTH = 8). The bench drives and samples the DUT on the falling edge.
module tb_serial_adder;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
`ifdef SERIAL_ADDER_SUB_EN
    logic             sub;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             busy;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int n_acc    = 0;
    int acc_cyc [64];

    serial_adder #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .cin      (cin),
`ifdef SERIAL_ADDER_SUB_EN
        .sub      (sub),
`endif
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum      (sum),
        .cout     (cout),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record the cycle number of each accepting edge.
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (rst_n && in_valid && in_ready && n_acc < 64) begin
            acc_cyc[n_acc] = cyc;
            n_acc = n_acc + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive one operand pair, let it be accepted, then drop in_valid.
    task automatic start_op(input logic [7:0] va, input logic [7:0] vb, input logic vc, input logic vs);
        a        = va;
        b        = vb;
        cin      = vc;
`ifdef SERIAL_ADDER_SUB_EN
        sub      = vs;
`else
        if (vs) $display("note: sub requested without SERIAL_ADDER_SUB_EN");
`endif
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Count rising edges until out_valid is seen, up to a bounded budget.
    task automatic wait_done(output int lat);
        lat = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (out_valid) break;
        end
        check("done_seen", 32'(out_valid), 32'd1);
    endtask

    task automatic run_op(input string tag, input logic [7:0] va, input logic [7:0] vb,
                          input logic vc, input logic vs, input logic [7:0] esum, input logic ecout);
        int lat;
        start_op(va, vb, vc, vs);
        wait_done(lat);
        check({tag, "_lat"},  32'(lat),  32'd8);
        check({tag, "_sum"},  32'(sum),  32'(esum));
        check({tag, "_cout"}, 32'(cout), 32'(ecout));
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_idle"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        int lat;
        int base;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
        sub       = 1'b0;
`endif
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Post-reset state
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_sum",       32'(sum),       32'h00);
        check("rst_cout",      32'(cout),      32'd0);
        check("rst_busy",      32'(busy),      32'd0);

        // Latency and full carry ripple: FF + 01 + 0 = 0x100
        run_op("ff_01", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1);

        // Backpressure: 5A + A5 + 1 = 0x100, out_ready held low for 5 cycles
        start_op(8'h5A, 8'hA5, 1'b1, 1'b0);
        check("bp_busy_add", 32'(busy), 32'd1);
        wait_done(lat);
        check("bp_lat",  32'(lat),  32'd8);
        check("bp_sum",  32'(sum),  32'h00);
        check("bp_cout", 32'(cout), 32'd1);
        for (int i = 0; i < 5; i++) begin
            if (i == 1) begin
                a = 8'h33; b = 8'h44; cin = 1'b0; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk);
            @(negedge clk);
            check("bp_hold_valid", 32'(out_valid), 32'd1);
            check("bp_hold_sum",   32'(sum),       32'h00);
            check("bp_hold_cout",  32'(cout),      32'd1);
            check("bp_hold_ready", 32'(in_ready),  32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("bp_release_idle",  32'(in_ready),  32'd1);
        check("bp_release_valid", 32'(out_valid), 32'd0);
        check("bp_kept_sum",      32'(sum),       32'h00);
        check("bp_kept_cout",     32'(cout),      32'd1);
        @(posedge clk);
        @(negedge clk);
        check("bp_pulse_ignored", 32'(busy), 32'd0);

        // Reset in the 3rd ADD cycle aborts immediately
        start_op(8'h77, 8'h11, 1'b0, 1'b0);
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
        end
        check("abort_busy_before", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_in_ready",  32'(in_ready),  32'd1);
        check("abort_busy",      32'(busy),      32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op("p12_34", 8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0);

        // Back-to-back with in_valid and out_ready held high
        base      = n_acc;
        out_ready = 1'b1;
        a = 8'h80; b = 8'h80; cin = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        wait_done(lat);
        check("b2b1_lat",  32'(lat),  32'd8);
        check("b2b1_sum",  32'(sum),  32'h00);
        check("b2b1_cout", 32'(cout), 32'd1);
        a = 8'h0F; b = 8'h01;
        wait_done(lat);
        check("b2b2_sum",  32'(sum),  32'h10);
        check("b2b2_cout", 32'(cout), 32'd0);
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("b2b_accepts", 32'(n_acc - base), 32'd2);
        if (n_acc - base >= 2)
            check("b2b_interval", 32'(acc_cyc[base+1] - acc_cyc[base]), 32'd10);

`ifdef SERIAL_ADDER_SUB_EN
        // Subtract: 10 - 01 = 0F with no borrow; 01 - 02 = FF with borrow
        run_op("sub_10_01", 8'h10, 8'h01, 1'b0, 1'b1, 8'h0F, 1'b1);
        run_op("sub_01_02", 8'h01, 8'h02, 1'b0, 1'b1, 8'hFF, 1'b0);
        run_op("sub0_add",  8'h21, 8'h13, 1'b1, 1'b0, 8'h35, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Hard stop so that a stuck DUT cannot hang the run.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial N-bit adder built around the half-adder stage: one sum bit per clock, LSB first.
- Per bit: two half-adders plus an OR, with a registered carry between cycles.
- Consumes operand pairs over a valid/ready handshake and produces an N-bit sum plus carry-out over a second valid/ready handshake.
- Sits directly downstream of the half_adder cell as the first sequential consumer of its sum/carry outputs.

Parameters:
- WIDTH, 8, operand and sum width in bits; legal range is WIDTH >= 1.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand pair presented.
- in_ready  output  1  block can accept operands; high only in IDLE.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in for the LSB.
- out_valid  output  1  sum/cout valid; high only in DONE.
- out_ready  input  1  consumer accepts result.
- sum  output  WIDTH  registered result.
- cout  output  1  registered carry-out of the MSB.
- busy  output  1  high in ADD or DONE.

Behaviour:
- Reset (rst_n low, asynchronous):
  - State goes to IDLE; bit counter = 0; carry register = 0.
  - Operand shift registers = 0; sum = 0; cout = 0; out_valid = 0; busy = 0; in_ready = 1.
- States are IDLE, ADD and DONE. in_ready, out_valid and busy are decoded from the state only.
- IDLE:
  - in_ready = 1.
  - On a rising edge with in_valid = 1: latch a and b into shift registers, set carry to cin, set count to 0, go to ADD.
  - in_valid = 0: remain in IDLE.
- ADD, every edge:
  - s = a_sh[0] ^ b_sh[0] ^ c.
  - c' = (a_sh[0] & b_sh[0]) | (c & (a_sh[0] ^ b_sh[0])).
  - Sum shift register shifts right with s inserted at bit WIDTH-1; a_sh and b_sh shift right; count increments.
  - On the edge where count reaches WIDTH-1 (the last bit): go to DONE and load cout = c'.
- DONE:
  - out_valid = 1; sum and cout are held stable.
  - When out_ready = 1 on an edge, go to IDLE.
  - sum and cout keep their last values after the handshake until the next result overwrites them.
- Timing:
  - Latency: out_valid rises exactly WIDTH edges after the accepting edge.
  - WIDTH = 1 gives a single ADD cycle.
  - No overlap: minimum interval between accepts is WIDTH+2 cycles with out_ready held high.
- Inputs a, b, cin and in_valid are ignored while in_ready = 0.
- Backpressure: out_ready low holds DONE indefinitely with outputs unchanged.
- Reset asserted mid-ADD or in DONE aborts the operation immediately; no partial result is ever presented.
- Arithmetic: {cout, sum} = a + b + cin, exact modulo 2^(WIDTH+1).
- Counter width is $clog2(WIDTH+1); it never wraps within an operation.

Optional Feature:
- Macro: SERIAL_ADDER_SUB_EN.
- Defined:
  - Adds input port sub (1 bit), sampled with the operands at the accepting edge.
  - sub = 1: b is latched inverted (~b), the carry register is initialised to 1 and cin is ignored.
  - Result is sum = a - b mod 2^WIDTH, with cout = 1 meaning no borrow (a >= b unsigned).
  - sub = 0: identical to the base adder.
- Not defined: no sub port; add only.

Test Plan (WIDTH = 8):
- Post-reset checks → in_ready = 1, out_valid = 0, sum = 0x00, cout = 0, busy = 0.
- Latency and carry: a = 0xFF, b = 0x01, cin = 0 → out_valid rises exactly 8 edges after accept; sum = 0x00, cout = 1.
- a = 0x5A, b = 0xA5, cin = 1, then out_ready held low 5 cycles → sum = 0x00, cout = 1.
  - out_valid, sum and cout stay stable throughout.
  - in_ready = 0; a second in_valid pulse is ignored.
  - Release out_ready → IDLE on the next edge.
- Reset mid-operation: assert rst_n = 0 on the 3rd ADD cycle → out_valid = 0 and in_ready = 1 immediately. Then 0x12 + 0x34, cin = 0 → sum = 0x46, cout = 0.
- Back-to-back with out_ready = 1 and in_valid held high:
  - 0x80 + 0x80 → sum = 0x00, cout = 1.
  - 0x0F + 0x01 → sum = 0x10, cout = 0.
  - Second accept occurs exactly 10 cycles after the first.
- With SERIAL_ADDER_SUB_EN defined:
  - a = 0x10, b = 0x01, sub = 1 → sum = 0x0F, cout = 1.
  - a = 0x01, b = 0x02, sub = 1 → sum = 0xFF, cout = 0.
